// File: rtl/ssd_scan_drv.sv
// Four-digit multiplexed seven-segment scanner with a double-buffered BCD
// load path, frame-aligned updates, leading-zero blanking and a sticky error flag.
module ssd_scan_drv #(
  parameter logic [15:0] CNT_END  = 16'hC350,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] BCD_IN,
  input  logic [3:0]  DP_IN,
  input  logic        LOAD,
  output logic        PENDING,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        ERR
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned NDIG   = 4;
  localparam int unsigned DATA_W = 4 * NDIG;

  logic [CNT_W-1:0]  presc;
  logic [1:0]        dig;
  logic [DATA_W-1:0] shadow_bcd, active_bcd;
  logic [NDIG-1:0]   shadow_dp, active_dp;

  logic        tick_c;
  logic        frame_apply_c;
  logic        shadow_bad_c;
  logic [3:0]  lz_c;
  logic        blank_c;
  logic [3:0]  nib_c;
  logic [3:0]  an_c;
  logic [6:0]  seg_c;
  logic        dp_c;

  // Active-low segment pattern, g..a; anything outside 0-9 shows a dash
  function automatic logic [6:0] seg_dec(input logic [3:0] n);
    case (n)
      4'd0:    seg_dec = 7'h40;
      4'd1:    seg_dec = 7'h79;
      4'd2:    seg_dec = 7'h24;
      4'd3:    seg_dec = 7'h30;
      4'd4:    seg_dec = 7'h19;
      4'd5:    seg_dec = 7'h12;
      4'd6:    seg_dec = 7'h02;
      4'd7:    seg_dec = 7'h78;
      4'd8:    seg_dec = 7'h00;
      4'd9:    seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  endfunction

  always_comb begin
    tick_c        = (presc == CNT_END);
    frame_apply_c = tick_c && (dig == 2'd3) && PENDING;
    shadow_bad_c  = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (shadow_bcd[4*i +: 4] > 4'd9) shadow_bad_c = 1'b1;
    end
  end

  // lz_c[d] is set when nibbles d..3 of the active value are all zero
  always_comb begin
    lz_c    = '0;
    lz_c[3] = (active_bcd[15:12] == 4'd0);
    lz_c[2] = lz_c[3] && (active_bcd[11:8] == 4'd0);
    lz_c[1] = lz_c[2] && (active_bcd[7:4] == 4'd0);
    lz_c[0] = 1'b0;
    blank_c = BLANK_LZ && (dig != 2'd0) && lz_c[dig];
    nib_c   = active_bcd[{dig, 2'b00} +: 4];
    an_c    = 4'hF;
    seg_c   = 7'h7F;
    dp_c    = 1'b1;
    if (!blank_c) begin
      an_c  = 4'(~(4'b0001 << dig));
      seg_c = seg_dec(nib_c);
      dp_c  = ~active_dp[dig];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      presc      <= '0;
      dig        <= '0;
      shadow_bcd <= '0;
      shadow_dp  <= '0;
      active_bcd <= '0;
      active_dp  <= '0;
      PENDING    <= 1'b0;
      AN         <= 4'hF;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
      ERR        <= 1'b0;
    end else begin
      presc <= tick_c ? '0 : CNT_W'(presc + 1'b1);
      if (tick_c) dig <= 2'(dig + 1'b1);

      // A load on the boundary still lets the previous shadow reach the display
      if (frame_apply_c) begin
        active_bcd <= shadow_bcd;
        active_dp  <= shadow_dp;
        if (shadow_bad_c) ERR <= 1'b1;
      end
      if (LOAD) begin
        shadow_bcd <= BCD_IN;
        shadow_dp  <= DP_IN;
        PENDING    <= 1'b1;
      end else if (frame_apply_c) begin
        PENDING <= 1'b0;
      end

      AN  <= an_c;
      SEG <= seg_c;
      DP  <= dp_c;
    end
  end

endmodule

// File: tb/tb_ssd_scan_drv.sv
// Directed bench for ssd_scan_drv with CNT_END = 3: edge counting from reset
// release places every frame boundary at edge 16m+15.
module tb_ssd_scan_drv;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] BCD_IN;
  logic [3:0]  DP_IN;
  logic        LOAD;
  logic        PENDING;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;
  logic        ERR;

  int n_checks = 0;
  int n_errors = 0;
  int ecnt     = -1;

  ssd_scan_drv #(.CNT_END(16'd3), .BLANK_LZ(1'b1)) dut (
    .CLK(CLK), .RST(RST), .BCD_IN(BCD_IN), .DP_IN(DP_IN), .LOAD(LOAD),
    .PENDING(PENDING), .AN(AN), .SEG(SEG), .DP(DP), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Advance one clock; ecnt counts edges since reset release (release edge = 0)
  task automatic step();
    @(posedge CLK);
    if (RST) ecnt++;
    #1;
  endtask

  task automatic goto_edge(input int t);
    while (ecnt < t) step();
  endtask

  // LOAD is captured on the edge numbered ecnt+1
  task automatic load(input logic [15:0] bcd, input logic [3:0] dp);
    BCD_IN = bcd;
    DP_IN  = dp;
    LOAD   = 1'b1;
    step();
    LOAD   = 1'b0;
  endtask

  task automatic check_disp(input string tag, input int t, input logic [3:0] an,
                            input logic [6:0] seg, input logic dp);
    goto_edge(t);
    check({tag, ".an"},  16'(AN),  16'(an));
    check({tag, ".seg"}, 16'(SEG), 16'(seg));
    check({tag, ".dp"},  16'(DP),  16'(dp));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".an"},  16'(AN),      16'hF);
    check({tag, ".seg"}, 16'(SEG),     16'h7F);
    check({tag, ".dp"},  16'(DP),      16'h1);
    check({tag, ".err"}, 16'(ERR),     16'h0);
    check({tag, ".pnd"}, 16'(PENDING), 16'h0);
  endtask

  initial begin
    RST = 1'b0; LOAD = 1'b1; BCD_IN = 16'h9999; DP_IN = 4'hF;
    step(); step();
    check_reset_vals("rst");
    LOAD = 1'b0;
    RST  = 1'b1;

    // First tick: digit 0 ('0') until edge 3, then blanked digit 1 at edge 4
    check_disp("pre_tick", 3, 4'b1110, 7'h40, 1'b1);
    check_disp("post_tick", 4, 4'hF, 7'h7F, 1'b1);

    load(16'h1234, 4'b0100);              // edge 5
    check("pnd_set", 16'(PENDING), 16'h1);
    goto_edge(14); check("pnd_hold", 16'(PENDING), 16'h1);
    goto_edge(15); check("pnd_clr", 16'(PENDING), 16'h0);
    check_disp("f0d0", 17, 4'b1110, 7'h19, 1'b1);
    check_disp("f0d1", 21, 4'b1101, 7'h30, 1'b1);
    check_disp("f0d2", 25, 4'b1011, 7'h24, 1'b0);
    check_disp("f0d3", 29, 4'b0111, 7'h79, 1'b1);

    load(16'h0007, 4'b0011);              // edge 30, shown from frame at 31
    check_disp("lz_d0", 33, 4'b1110, 7'h78, 1'b0);
    check_disp("lz_d1", 37, 4'hF, 7'h7F, 1'b1);
    check_disp("lz_d2", 41, 4'hF, 7'h7F, 1'b1);
    check_disp("lz_d3", 45, 4'hF, 7'h7F, 1'b1);

    load(16'h0000, 4'b0000);              // edge 46, frame at 47
    check_disp("zero_d0", 49, 4'b1110, 7'h40, 1'b1);
    check_disp("zero_d1", 53, 4'hF, 7'h7F, 1'b1);
    check("err_clean", 16'(ERR), 16'h0);

    load(16'h00A5, 4'b0000);              // edge 54, frame at 63
    goto_edge(62); check("err_pre", 16'(ERR), 16'h0);
    goto_edge(64); check("err_set", 16'(ERR), 16'h1);
    check_disp("hex_d0", 65, 4'b1110, 7'h12, 1'b1);
    check_disp("hex_d1", 69, 4'b1101, 7'h3F, 1'b1);
    check_disp("hex_d2", 73, 4'hF, 7'h7F, 1'b1);

    load(16'h0001, 4'b0000);              // edge 74, frame at 79
    check_disp("one_d0", 81, 4'b1110, 7'h79, 1'b1);
    check("err_sticky", 16'(ERR), 16'h1);

    load(16'h1111, 4'b0000);              // edge 82
    step();
    load(16'h2222, 4'b0000);              // edge 84, frame at 95
    goto_edge(90); check("ovr_pnd", 16'(PENDING), 16'h1);
    check_disp("ovr_d0", 97, 4'b1110, 7'h24, 1'b1);
    goto_edge(99);
    load(16'h3333, 4'b0000);              // edge 100
    check_disp("ovr_d3", 109, 4'b0111, 7'h24, 1'b1);

    goto_edge(110);
    load(16'h4444, 4'b0000);              // edge 111 is a frame-boundary tick
    check("bnd_pnd", 16'(PENDING), 16'h1);
    goto_edge(112); check("bnd_pnd2", 16'(PENDING), 16'h1);
    check_disp("bnd_d0", 113, 4'b1110, 7'h30, 1'b1);
    goto_edge(126); check("bnd_pnd3", 16'(PENDING), 16'h1);
    goto_edge(127); check("bnd_clr", 16'(PENDING), 16'h0);
    check_disp("bnd_next", 129, 4'b1110, 7'h19, 1'b1);

    goto_edge(131);
    load(16'h5555, 4'b1111);              // edge 132, pending
    check("mid_pnd", 16'(PENDING), 16'h1);
    goto_edge(134);
    RST = 1'b0;
    step();
    check_reset_vals("mid_rst");
    ecnt = -1;
    RST  = 1'b1;
    goto_edge(16); check("post_pnd", 16'(PENDING), 16'h0);
    check_disp("post_d0", 17, 4'b1110, 7'h40, 1'b1);
    check_disp("post_d1", 21, 4'hF, 7'h7F, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_drv.md
SSD_SCAN_DRV -- requirements
Module: ssd_scan_drv

Interface
REQ-001 SHALL provide parameter CNT_END, default 16'hC350, prescaler terminal count; one scan tick every CNT_END+1 clocks.
REQ-002 SHALL provide parameter BLANK_LZ, default 1, enables leading-zero blanking when 1.
REQ-003 SHALL provide port CLK  input  1  system clock; all logic on rising edge.
REQ-004 SHALL provide port RST  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL provide port BCD_IN  input  16  four BCD digits, [3:0] = digit 0 (rightmost).
REQ-006 SHALL provide port DP_IN  input  4  decimal-point enables, bit d = digit d, active-high.
REQ-007 SHALL provide port LOAD  input  1  one-cycle capture strobe for BCD_IN/DP_IN.
REQ-008 SHALL provide port PENDING  output  1  high while captured data awaits display.
REQ-009 SHALL provide port AN  output  4  anode selects, active-low, bit d = digit d.
REQ-010 SHALL provide port SEG  output  7  cathodes, active-low, SEG[6:0] = g,f,e,d,c,b,a.
REQ-011 SHALL provide port DP  output  1  decimal-point cathode, active-low.
REQ-012 SHALL provide port ERR  output  1  sticky flag, non-BCD nibble displayed.

Function
REQ-013 Prescaler SHALL count 0..CNT_END, assert internal tick for one clock when count == CNT_END, then wrap to 0.
REQ-014 Digit index DIG (2 bits) SHALL increment on each tick, wrapping 3 -> 0.
REQ-015 Frame boundary SHALL be a tick with DIG == 3.
REQ-016 LOAD SHALL copy BCD_IN and DP_IN into a shadow register and set PENDING on the next edge.
REQ-017 At a frame boundary with PENDING = 1, the shadow SHALL be copied to the active register and PENDING cleared.
REQ-018 LOAD while PENDING = 1 SHALL overwrite the shadow; only the latest load is displayed.
REQ-019 LOAD coinciding with a frame-boundary tick SHALL apply the prior shadow to active; the new data SHALL go to the shadow; PENDING SHALL stay 1.
REQ-020 AN, SEG and DP SHALL be registered and reflect the new DIG one clock after the tick (1-cycle latency).
REQ-021 For the selected digit d, AN SHALL drive bit d low and the other bits high, unless d is blanked.
REQ-022 With BLANK_LZ = 1, digit d > 0 SHALL be blanked when active nibbles d..3 all equal 0; blanked means AN = 4'hF, SEG = 7'h7F, DP = 1.
REQ-023 Digit 0 SHALL never be blanked.
REQ-024 Decode (hex, active-low) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-025 Nibbles A-F SHALL decode to a dash, 7'h3F.
REQ-026 ERR SHALL set when the active register is loaded with any nibble > 9.
REQ-027 ERR SHALL clear only on reset.
REQ-028 DP SHALL equal ~active_dp[d] for a non-blanked digit.
REQ-029 Blanking SHALL apply to DP as well.

Reset
REQ-030 While RST = 0 at a clock edge, the following SHALL take these values on that edge: prescaler = 0, DIG = 0, shadow = 0, active = 0, PENDING = 0, AN = 4'hF, SEG = 7'h7F, DP = 1, ERR = 0.
REQ-031 Reset SHALL override simultaneous LOAD or tick, including mid-frame.
REQ-032 The first tick after reset release SHALL occur CNT_END+1 clocks later.

Verification (CNT_END = 3 for simulation)
REQ-033 Hold RST = 0 for 2 clocks -> AN = F, SEG = 7F, DP = 1, ERR = 0, PENDING = 0; release -> tick 4 clocks later.
REQ-034 LOAD with 16'h1234, DP_IN = 4'b0100 -> PENDING = 1 until the next frame boundary, then 0. Subsequent frame: AN = 1110/SEG = 19; AN = 1101/SEG = 30; AN = 1011/SEG = 24/DP = 0; AN = 0111/SEG = 79.
REQ-035 LOAD 16'h0007, BLANK_LZ = 1 -> digit slots 1-3 give AN = F, SEG = 7F; digit 0 gives SEG = 78. LOAD 16'h0000 -> digit 0 gives SEG = 40.
REQ-036 LOAD 16'h00A5 -> digit 1 slot gives SEG = 3F and ERR = 1. Later LOAD 16'h0001 -> ERR remains 1.
REQ-037 LOAD 16'h1111 then 16'h2222 before a boundary -> 2222 displayed, 1111 never displayed. LOAD on a boundary tick -> PENDING stays 1, data applied at the next boundary.
REQ-038 Assert RST = 0 mid-frame with PENDING = 1 -> all reset values on that edge; the shadow data is never displayed.
